alu_exec: RTL and testbench

- Execution unit that consumes the 4-bit ALU operation code produced by the ALU control decoder and computes the result on two register/immediate operands.
- Single-cycle ops: ADD, SUB, OR, AND, SLT, SLL, and the immediate/address forms.
- Multi-cycle ops: MULT and DIV, iterative, signed, writing to Hi/Lo.
- Sits in the EX stage between the operand muxes and the EX/MEM register; the control FSM stalls on Busy.

---
 rtl/alu_exec.sv | 200 ++++++++++++++++++++
 tb/tb_alu_exec.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec.sv
// ============================================================================
// Module   : alu_exec
// Purpose  : EX-stage ALU with single-cycle ops plus iterative signed MULT/DIV
//            that write Hi/Lo.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_exec #(
  parameter int W  = 32,
  parameter int SW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          Start,
  input  logic [3:0]    IA,
  input  logic [W-1:0]  A,
  input  logic [W-1:0]  B,
  input  logic [SW-1:0] Shamt,
  output logic [W-1:0]  Res,
  output logic [W-1:0]  Hi,
  output logic [W-1:0]  Lo,
  output logic          Zero,
  output logic          Ovf,
  output logic          Dz,
  output logic          Err,
  output logic          Busy,
  output logic          Done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t          r_state;
  logic [2*W-1:0]  r_acc;
  logic [W-1:0]    r_opd;
  logic [SW-1:0]   r_cnt;
  logic            r_s1;
  logic            r_s2;
  logic            r_is_div;

  logic [W-1:0]    w_abs_a;
  logic [W-1:0]    w_abs_b;
  logic [W-1:0]    w_sum;
  logic [W-1:0]    w_diff;
  logic [W-1:0]    w_res;
  logic            w_ovf;
  logic            w_err;

  logic [W:0]      w_mul_sum;
  logic [2*W-1:0]  w_mul_next;
  logic [W:0]      w_div_sh;
  logic [W:0]      w_div_diff;
  logic            w_div_ok;
  logic [2*W-1:0]  w_div_next;

  logic [2*W-1:0]  w_prod_fix;
  logic [W-1:0]    w_quo;
  logic [W-1:0]    w_rem;
  logic [W-1:0]    w_fix_hi;
  logic [W-1:0]    w_fix_lo;

  assign w_abs_a = A[W-1] ? (~A + 1'b1) : A;
  assign w_abs_b = B[W-1] ? (~B + 1'b1) : B;
  assign w_sum   = A + B;
  assign w_diff  = A - B;

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    w_err = 1'b0;
    case (IA)
      4'b0000, 4'b1000, 4'b1100, 4'b1101: begin
        w_res = w_sum;
        w_ovf = (A[W-1] == B[W-1]) && (w_sum[W-1] != A[W-1]);
      end
      4'b0001: begin
        w_res = w_diff;
        w_ovf = (A[W-1] != B[W-1]) && (w_diff[W-1] != A[W-1]);
      end
      4'b0100, 4'b1011: w_res = A | B;
      4'b0101, 4'b1010: w_res = A & B;
      4'b0110, 4'b1001: w_res = {{(W-1){1'b0}}, ($signed(A) < $signed(B))};
      4'b0111:          w_res = B << Shamt;
      default:          w_err = 1'b1;
    endcase
  end

  // Shift-add: low half holds the remaining multiplier bits, high half accumulates.
  assign w_mul_sum  = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_opd} : {(W+1){1'b0}});
  assign w_mul_next = {w_mul_sum, r_acc[W-1:1]};

  // Restoring division: high half is the partial remainder, low half the dividend/quotient.
  assign w_div_sh   = {r_acc[2*W-1:W], r_acc[W-1]};
  assign w_div_diff = w_div_sh - {1'b0, r_opd};
  assign w_div_ok   = ~w_div_diff[W];
  assign w_div_next = {(w_div_ok ? w_div_diff[W-1:0] : w_div_sh[W-1:0]),
                       r_acc[W-2:0], w_div_ok};

  assign w_prod_fix = r_s1 ? (~r_acc + 1'b1) : r_acc;
  assign w_quo      = r_s1 ? (~r_acc[W-1:0] + 1'b1) : r_acc[W-1:0];
  assign w_rem      = r_s2 ? (~r_acc[2*W-1:W] + 1'b1) : r_acc[2*W-1:W];
  assign w_fix_hi   = r_is_div ? w_rem : w_prod_fix[2*W-1:W];
  assign w_fix_lo   = r_is_div ? w_quo : w_prod_fix[W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_acc    <= '0;
      r_opd    <= '0;
      r_cnt    <= '0;
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_is_div <= 1'b0;
      Res      <= '0;
      Hi       <= '0;
      Lo       <= '0;
      Zero     <= 1'b1;
      Ovf      <= 1'b0;
      Dz       <= 1'b0;
      Err      <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            Ovf <= 1'b0;
            Dz  <= 1'b0;
            Err <= 1'b0;
            case (IA)
              4'b0010: begin
                r_acc    <= {{W{1'b0}}, w_abs_b};
                r_opd    <= w_abs_a;
                r_s1     <= A[W-1] ^ B[W-1];
                r_s2     <= 1'b0;
                r_is_div <= 1'b0;
                r_cnt    <= '0;
                Busy     <= 1'b1;
                r_state  <= S_MUL;
              end
              4'b0011: begin
                if (B == '0) begin
                  Lo   <= '1;
                  Hi   <= A;
                  Dz   <= 1'b1;
                  Zero <= 1'b0;
                  Done <= 1'b1;
                end else begin
                  r_acc    <= {{W{1'b0}}, w_abs_a};
                  r_opd    <= w_abs_b;
                  r_s1     <= A[W-1] ^ B[W-1];
                  r_s2     <= A[W-1];
                  r_is_div <= 1'b1;
                  r_cnt    <= '0;
                  Busy     <= 1'b1;
                  r_state  <= S_DIV;
                end
              end
              default: begin
                Res  <= w_res;
                Zero <= (w_res == '0);
                Ovf  <= w_ovf;
                Err  <= w_err;
                Done <= 1'b1;
              end
            endcase
          end
        end
        S_MUL: begin
          r_acc <= w_mul_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == SW'(W-1)) r_state <= S_FIX;
        end
        S_DIV: begin
          r_acc <= w_div_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == SW'(W-1)) r_state <= S_FIX;
        end
        S_FIX: begin
          Hi      <= w_fix_hi;
          Lo      <= w_fix_lo;
          Zero    <= (w_fix_lo == '0);
          Busy    <= 1'b0;
          Done    <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_exec.sv
// ============================================================================
// Module   : tb_alu_exec
// Purpose  : Directed vector bench for alu_exec, single-cycle table plus
//            MULT/DIV, divide-by-zero, back-to-back and reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_exec;

  localparam int W  = 32;
  localparam int SW = 5;

  logic          clk;
  logic          rst_n;
  logic          Start;
  logic [3:0]    IA;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic [SW-1:0] Shamt;
  logic [W-1:0]  Res;
  logic [W-1:0]  Hi;
  logic [W-1:0]  Lo;
  logic          Zero;
  logic          Ovf;
  logic          Dz;
  logic          Err;
  logic          Busy;
  logic          Done;

  int checks = 0;
  int errors = 0;

  alu_exec #(.W(W), .SW(SW)) dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .IA(IA), .A(A), .B(B), .Shamt(Shamt),
    .Res(Res), .Hi(Hi), .Lo(Lo), .Zero(Zero), .Ovf(Ovf), .Dz(Dz), .Err(Err),
    .Busy(Busy), .Done(Done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]    ia;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [SW-1:0] sh;
    logic [W-1:0]  res;
    logic          zero;
    logic          ovf;
    logic          err;
  } vec_t;

  vec_t vec[14];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive a request for one edge; returns #1 after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [SW-1:0] sh);
    IA = op; A = a; B = b; Shamt = sh; Start = 1'b1;
    @(posedge clk);
    #1;
    Start = 1'b0;
  endtask

  // Issue a MULT/DIV, poke ignored Starts while busy, return edges to Done and busy cycles.
  task automatic run_multi(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           output int edges, output int busy_cnt);
    issue(op, a, b, '0);
    edges    = 1;
    busy_cnt = Busy ? 1 : 0;
    while (!Done && edges < 100) begin
      Start = ((edges % 5) == 2);
      IA    = 4'b0000;
      A     = $urandom;
      B     = $urandom;
      @(posedge clk);
      #1;
      edges++;
      if (Busy) busy_cnt++;
    end
    Start = 1'b0;
    chk("multi_no_timeout", 64'(edges < 100), 64'd1);
  endtask

  logic [W-1:0] exp_res;
  logic [W-1:0] exp_hi;
  logic [W-1:0] exp_lo;
  int           edges;
  int           busy_cnt;

  initial begin
    rst_n = 1'b0; Start = 1'b0; IA = '0; A = '0; B = '0; Shamt = '0;
    exp_res = '0; exp_hi = '0; exp_lo = '0;

    vec[0]  = '{4'b0000, 32'd3,        32'd4,        5'd0,  32'd7,        1'b0, 1'b0, 1'b0};
    vec[1]  = '{4'b0000, 32'h7FFFFFFF, 32'd1,        5'd0,  32'h80000000, 1'b0, 1'b1, 1'b0};
    vec[2]  = '{4'b0001, 32'd5,        32'd5,        5'd0,  32'd0,        1'b1, 1'b0, 1'b0};
    vec[3]  = '{4'b0001, 32'h80000000, 32'd1,        5'd0,  32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
    vec[4]  = '{4'b1011, 32'h0000F0F0, 32'h00000F0F, 5'd0,  32'h0000FFFF, 1'b0, 1'b0, 1'b0};
    vec[5]  = '{4'b0101, 32'hFF00FF00, 32'h0F0F0F0F, 5'd0,  32'h0F000F00, 1'b0, 1'b0, 1'b0};
    vec[6]  = '{4'b0110, 32'hFFFFFFFF, 32'd1,        5'd0,  32'd1,        1'b0, 1'b0, 1'b0};
    vec[7]  = '{4'b1001, 32'd1,        32'hFFFFFFFF, 5'd0,  32'd0,        1'b1, 1'b0, 1'b0};
    vec[8]  = '{4'b0111, 32'd0,        32'd1,        5'd31, 32'h80000000, 1'b0, 1'b0, 1'b0};
    vec[9]  = '{4'b1110, 32'd9,        32'd9,        5'd0,  32'd0,        1'b1, 1'b0, 1'b1};
    vec[10] = '{4'b1101, 32'hFFFFFFFF, 32'd1,        5'd0,  32'd0,        1'b1, 1'b0, 1'b0};
    vec[11] = '{4'b1100, 32'h80000000, 32'h80000000, 5'd0,  32'd0,        1'b1, 1'b1, 1'b0};
    vec[12] = '{4'b1111, 32'd5,        32'd6,        5'd0,  32'd0,        1'b1, 1'b0, 1'b1};
    vec[13] = '{4'b1000, 32'd10,       32'hFFFFFFFE, 5'd0,  32'd8,        1'b0, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_res",  64'(Res),  64'd0);
    chk("rst_hilo", {Hi, Lo},  64'd0);
    chk("rst_zero", 64'(Zero), 64'd1);
    chk("rst_flags", {59'd0, Ovf, Dz, Err, Busy, Done}, 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      issue(vec[i].ia, vec[i].a, vec[i].b, vec[i].sh);
      chk($sformatf("v%0d_res", i),  64'(Res),  64'(vec[i].res));
      chk($sformatf("v%0d_zero", i), 64'(Zero), 64'(vec[i].zero));
      chk($sformatf("v%0d_ovf", i),  64'(Ovf),  64'(vec[i].ovf));
      chk($sformatf("v%0d_err", i),  64'(Err),  64'(vec[i].err));
      chk($sformatf("v%0d_done_busy_dz", i), {61'd0, Done, Busy, Dz}, 64'b100);
      chk($sformatf("v%0d_hilo", i), {Hi, Lo}, {exp_hi, exp_lo});
      exp_res = vec[i].res;
    end
    @(posedge clk); #1;
    chk("done_one_cycle", 64'(Done), 64'd0);

    // MULT -3 * 7
    run_multi(4'b0010, 32'hFFFFFFFD, 32'd7, edges, busy_cnt);
    chk("mult_latency", 64'(edges), 64'd34);
    chk("mult_busy_cycles", 64'(busy_cnt), 64'd33);
    chk("mult_hilo", {Hi, Lo}, 64'hFFFFFFFF_FFFFFFEB);
    chk("mult_res_held", 64'(Res), 64'(exp_res));
    chk("mult_flags", {60'd0, Zero, Ovf, Dz, Err}, 64'd0);
    @(posedge clk); #1;
    chk("mult_done_pulse", {62'd0, Done, Busy}, 64'd0);

    // MULT most-negative squared
    run_multi(4'b0010, 32'h80000000, 32'h80000000, edges, busy_cnt);
    chk("mult_min_hilo", {Hi, Lo}, 64'h40000000_00000000);
    chk("mult_min_zero", 64'(Zero), 64'd1);

    // DIV -7 / 2, then OR in the Done cycle
    run_multi(4'b0011, 32'hFFFFFFF9, 32'd2, edges, busy_cnt);
    chk("div_latency", 64'(edges), 64'd34);
    chk("div_hilo", {Hi, Lo}, 64'hFFFFFFFF_FFFFFFFD);
    chk("div_done", 64'(Done), 64'd1);
    issue(4'b0100, 32'h000000F0, 32'h0000000F, '0);
    chk("b2b_res", 64'(Res), 64'h000000FF);
    chk("b2b_done", {62'd0, Done, Busy}, 64'b10);
    chk("b2b_hilo", {Hi, Lo}, 64'hFFFFFFFF_FFFFFFFD);

    // DIV 7 / -2 : truncating quotient, remainder takes dividend sign
    run_multi(4'b0011, 32'd7, 32'hFFFFFFFE, edges, busy_cnt);
    chk("div_pos_neg", {Hi, Lo}, 64'h00000001_FFFFFFFD);

    // DIV most-negative / -1 wraps, no flag
    run_multi(4'b0011, 32'h80000000, 32'hFFFFFFFF, edges, busy_cnt);
    chk("div_min_hilo", {Hi, Lo}, 64'h00000000_80000000);
    chk("div_min_flags", {61'd0, Ovf, Dz, Err}, 64'd0);

    // DIV by zero
    issue(4'b0011, 32'd9, 32'd0, '0);
    chk("dz_hilo", {Hi, Lo}, 64'h00000009_FFFFFFFF);
    chk("dz_flag_done_busy", {61'd0, Dz, Done, Busy}, 64'b110);
    @(posedge clk); #1;
    chk("dz_after", {62'd0, Done, Busy}, 64'd0);

    // Reset in the middle of a MULT
    issue(4'b0010, 32'd12345, 32'd678, '0);
    repeat (9) @(posedge clk);
    #2;
    chk("pre_rst_busy", 64'(Busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_res_hilo", {Res, Hi, Lo} == '0 ? 64'd1 : 64'd0, 64'd1);
    chk("mid_rst_flags", {58'd0, Zero, Ovf, Dz, Err, Busy, Done}, 64'b100000);
    @(negedge clk);
    rst_n = 1'b1;
    issue(4'b0000, 32'd3, 32'd4, '0);
    chk("post_rst_add", {31'd0, Done, Res}, {31'd0, 1'b1, 32'd7});
    @(posedge clk); #1;
    chk("post_rst_done_clear", {62'd0, Done, Busy}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
